// File: rtl/exec_control_pkg.sv
// Shared types for the stack-machine sequencer: decoded-instruction struct,
// sequencer state encoding and comparison codes.
package ctrl_pkg;

    parameter int DEC_DATA_W = 32;

    typedef struct packed {
        logic [3:0]            aluop;
        logic                  isaluop;
        logic                  iscmp;
        logic [3:0]            cmptype;
        logic                  isargpush;
        logic [1:0]            argc;
        logic [1:0]            stackargs;
        logic                  stackwb;
        logic                  constpush;
        logic [DEC_DATA_W-1:0] constval;
        logic                  wide;
    } dec_t;

    typedef enum logic [2:0] {
        IDLE,
        POP_REQ,
        POP_WAIT,
        COMP,
        EXEC,
        PUSH_REQ,
        PUSH_WAIT
    } state_t;

    typedef enum logic [2:0] {
        CMP_EQ,
        CMP_NE,
        CMP_LT,
        CMP_LE,
        CMP_GE,
        CMP_GT
    } comp_types;

endpackage

// File: rtl/exec_control_if.sv
// Bundle of the decoder handshake, stack bus, ALU and branch signals around
// the sequencer; slave is the sequencer's view, master its environment's.
interface exec_control_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    import ctrl_pkg::*;

    logic              instr_valid;
    logic              instr_ready;
    dec_t              dec;
    logic [7:0]        arg1;
    logic [7:0]        arg2;
    logic [DATA_W-1:0] stack_rdata;
    logic              stack_done;
    logic [DATA_W-1:0] stack_wdata;
    logic              stack_push;
    logic              stack_trigger;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_lo;
    logic [DATA_W-1:0] alu_hi;
    logic              jmp;
    logic [ADDR_W-1:0] jmp_addr;
    logic              op_done;

    modport slave (
        input  instr_valid, dec, arg1, arg2, stack_rdata, stack_done, alu_lo, alu_hi,
        output instr_ready, stack_wdata, stack_push, stack_trigger, alu_op, alu_a, alu_b,
               jmp, jmp_addr, op_done
    );

    modport master (
        output instr_valid, dec, arg1, arg2, stack_rdata, stack_done, alu_lo, alu_hi,
        input  instr_ready, stack_wdata, stack_push, stack_trigger, alu_op, alu_a, alu_b,
               jmp, jmp_addr, op_done
    );

endinterface

// File: rtl/exec_control_cmp_unit.sv
// Combinational branch comparator: lhs a against b (or zero when cmptype[3]
// is clear), signed or unsigned by parameter. Also used by the branch predictor.
module cmp_unit #(
    parameter int W          = 32,
    parameter int SIGNED_CMP = 1
) (
    input  logic [3:0]   cmptype,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         hit
);
    import ctrl_pkg::*;

    logic [W-1:0] rhs;
    logic         eq;
    logic         lt;

    always_comb begin
        rhs = cmptype[3] ? b : '0;
        eq  = (a == rhs);
        if (SIGNED_CMP != 0) lt = ($signed(a) < $signed(rhs));
        else                 lt = (a < rhs);
        hit = 1'b0;
        case (cmptype[2:0])
            CMP_EQ:  hit = eq;
            CMP_NE:  hit = ~eq;
            CMP_LT:  hit = lt;
            CMP_LE:  hit = lt | eq;
            CMP_GE:  hit = ~lt;
            CMP_GT:  hit = ~(lt | eq);
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_control.sv
// Fetch-execute sequencer: pops operands, drives ALU/comparator, pushes results.
// Optional WIDE_PUSH_EN adds a second push of alu_hi for wide ALU instructions.
module exec_control #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int MAX_POP    = 3,
    parameter int SIGNED_CMP = 1
) (
    input logic          clk,
    input logic          rst,
    exec_control_if.slave bus
);
    import ctrl_pkg::*;

    state_t            state;
    state_t            state_next;
    dec_t              dec_q;
    logic [7:0]        arg1_q;
    logic [7:0]        arg2_q;
    logic [1:0]        cnt;
    logic [1:0]        pop_idx;
    logic [DATA_W-1:0] opnd [MAX_POP];
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] push_sel;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [15:0]       arg_word;
    logic              jmp_q;
    logic [ADDR_W-1:0] jmp_addr_q;
    logic              op_done_q;
    logic              cmp_hit;
    logic              handshake;
    logic              wide_next;

    assign handshake = bus.instr_valid && (state == IDLE);
    assign pop_idx   = dec_q.stackargs - cnt;

`ifdef WIDE_PUSH_EN
    logic hi_phase;
    assign wide_next = dec_q.wide & dec_q.isaluop & ~hi_phase;
`else
    logic unused_wide;
    assign wide_next   = 1'b0;
    assign unused_wide = ^{bus.alu_hi, dec_q.wide};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (handshake) state_next = (bus.dec.stackargs != 2'd0) ? POP_REQ : EXEC;
            POP_REQ:   state_next = POP_WAIT;
            POP_WAIT: begin
                if (bus.stack_done) begin
                    if (cnt == 2'd1) state_next = dec_q.iscmp ? COMP : EXEC;
                    else             state_next = POP_REQ;
                end
            end
            COMP:      state_next = EXEC;
            EXEC:      state_next = dec_q.stackwb ? PUSH_REQ : IDLE;
            PUSH_REQ:  state_next = PUSH_WAIT;
            PUSH_WAIT: if (bus.stack_done) state_next = wide_next ? PUSH_REQ : IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Operand routing: with two or more pops the deeper word is the lhs.
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        if (dec_q.stackargs >= 2'd2) begin
            alu_a = opnd[1];
            alu_b = opnd[0];
        end else if (dec_q.stackargs == 2'd1) begin
            alu_a = opnd[0];
        end
    end

    always_comb begin
        arg_word = (dec_q.argc == 2'd1) ? {{8{arg1_q[7]}}, arg1_q} : {arg1_q, arg2_q};
        push_sel = '0;
        if (dec_q.isaluop)                              push_sel = bus.alu_lo;
        else if (dec_q.constpush)                       push_sel = DATA_W'(dec_q.constval);
        else if (dec_q.isargpush && dec_q.argc != 2'd0) push_sel = DATA_W'($signed(arg_word));
    end

    cmp_unit #(.W(DATA_W), .SIGNED_CMP(SIGNED_CMP)) u_cmp (
        .cmptype (dec_q.cmptype),
        .a       (alu_a),
        .b       (alu_b),
        .hit     (cmp_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q      <= '0;
            arg1_q     <= '0;
            arg2_q     <= '0;
            cnt        <= '0;
            wdata_q    <= '0;
            jmp_q      <= 1'b0;
            jmp_addr_q <= '0;
            op_done_q  <= 1'b0;
            for (int i = 0; i < MAX_POP; i++) opnd[i] <= '0;
`ifdef WIDE_PUSH_EN
            hi_phase   <= 1'b0;
`endif
        end else begin
            op_done_q <= (state != IDLE) && (state_next == IDLE);
            case (state)
                IDLE: begin
                    if (handshake) begin
                        dec_q  <= bus.dec;
                        arg1_q <= bus.arg1;
                        arg2_q <= bus.arg2;
                        cnt    <= bus.dec.stackargs;
                        jmp_q  <= 1'b0;
                    end
                end
                POP_WAIT: begin
                    if (bus.stack_done) begin
                        for (int i = 0; i < MAX_POP; i++)
                            if (int'(pop_idx) == i) opnd[i] <= bus.stack_rdata;
                        cnt <= cnt - 2'd1;
                    end
                end
                COMP: begin
                    jmp_q      <= cmp_hit;
                    jmp_addr_q <= ADDR_W'({arg1_q, arg2_q});
                end
                EXEC: begin
                    wdata_q <= push_sel;
`ifdef WIDE_PUSH_EN
                    hi_phase <= 1'b0;
`endif
                end
`ifdef WIDE_PUSH_EN
                PUSH_WAIT: begin
                    if (bus.stack_done && wide_next) begin
                        wdata_q  <= bus.alu_hi;
                        hi_phase <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.instr_ready   = (state == IDLE);
    assign bus.stack_trigger = (state == POP_REQ) || (state == PUSH_REQ);
    assign bus.stack_push    = (state == PUSH_REQ) || (state == PUSH_WAIT);
    assign bus.stack_wdata   = wdata_q;
    assign bus.alu_op        = dec_q.aluop;
    assign bus.alu_a         = alu_a;
    assign bus.alu_b         = alu_b;
    assign bus.jmp           = jmp_q;
    assign bus.jmp_addr      = jmp_addr_q;
    assign bus.op_done       = op_done_q;

endmodule

// File: tb/tb_exec_control.sv
// Scoreboard bench for exec_control: a signed and an unsigned instance share
// stimulus and a 1-cycle stack model; pushes and completions are checked.
module tb_exec_control;
    import ctrl_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;

    typedef struct packed {
        logic [3:0]        pops;
        logic [3:0]        pushes;
        logic [7:0]        lat;
        logic              jmp;
        logic              jmp_u;
        logic              chk_addr;
        logic [ADDR_W-1:0] addr;
        logic              chk_alu;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    exec_control_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus   ();
    exec_control_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_u ();

    exec_control #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_POP(3), .SIGNED_CMP(1)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    exec_control #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_POP(3), .SIGNED_CMP(0)) dut_u (
        .clk (clk), .rst (rst), .bus (bus_u)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int hs_cyc      = 0;
    int pop_cnt     = 0;
    int push_cnt    = 0;

    logic              done_q;
    logic              stray_done;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] pop_q  [$];
    logic [DATA_W-1:0] push_q [$];
    exp_t              exp_q  [$];

    // Environment: 1-cycle stack and a simple ALU (lo = a + b, hi = b + 1).
    assign bus.stack_done    = done_q | stray_done;
    assign bus.stack_rdata   = rdata_q;
    assign bus.alu_lo        = bus.alu_a + bus.alu_b;
    assign bus.alu_hi        = bus.alu_b + 1;
    assign bus_u.instr_valid = bus.instr_valid;
    assign bus_u.dec         = bus.dec;
    assign bus_u.arg1        = bus.arg1;
    assign bus_u.arg2        = bus.arg2;
    assign bus_u.stack_done  = bus.stack_done;
    assign bus_u.stack_rdata = bus.stack_rdata;
    assign bus_u.alu_lo      = bus_u.alu_a + bus_u.alu_b;
    assign bus_u.alu_hi      = bus_u.alu_b + 1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            done_q <= bus.stack_trigger;
            if (bus.stack_trigger && !bus.stack_push) begin
                if (pop_q.size() > 0) rdata_q <= pop_q.pop_front();
                else                  rdata_q <= '0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.stack_trigger) begin
                if (bus.stack_push) begin
                    push_cnt++;
                    if (push_q.size() > 0) checkOutput("push_data", bus.stack_wdata, push_q.pop_front());
                    else                   checkOutput("unexpected_push", 1, 0);
                end else begin
                    pop_cnt++;
                end
            end
            if (bus.op_done) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_op_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("op_done_latency", cyc - hs_cyc, e.lat);
                    checkOutput("pop_triggers", pop_cnt, e.pops);
                    checkOutput("push_triggers", push_cnt, e.pushes);
                    checkOutput("ready_with_done", bus.instr_ready, 1);
                    checkOutput("jmp_signed", bus.jmp, e.jmp);
                    checkOutput("jmp_unsigned", bus_u.jmp, e.jmp_u);
                    if (e.chk_addr) checkOutput("jmp_addr", bus.jmp_addr, e.addr);
                    if (e.chk_alu) begin
                        checkOutput("alu_a", bus.alu_a, e.a);
                        checkOutput("alu_b", bus.alu_b, e.b);
                    end
                end
            end
            if (bus.instr_valid && bus.instr_ready) begin
                hs_cyc   = cyc;
                pop_cnt  = 0;
                push_cnt = 0;
            end
        end
    end

    function automatic dec_t blankDec();
        blankDec = '0;
    endfunction

    task automatic addExp(input int pops, input int pushes, input int lat, input logic j, input logic ju,
                          input logic chk_addr, input logic [ADDR_W-1:0] addr,
                          input logic chk_alu, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        exp_t e;
        e.pops = 4'(pops); e.pushes = 4'(pushes); e.lat = 8'(lat);
        e.jmp = j; e.jmp_u = ju; e.chk_addr = chk_addr; e.addr = addr;
        e.chk_alu = chk_alu; e.a = a; e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input dec_t d, input logic [7:0] a1, input logic [7:0] a2);
        logic ok;
        @(posedge clk); #1;
        bus.dec = d; bus.arg1 = a1; bus.arg2 = a2; bus.instr_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.instr_ready) begin ok = 1'b1; break; end
        end
        if (!ok) checkOutput("handshake_timeout", 0, 1);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && push_q.size() == 0) break;
            @(posedge clk); #2;
        end
        if (exp_q.size() != 0 || push_q.size() != 0) begin
            checkOutput("completion_timeout", exp_q.size() + push_q.size(), 0);
            exp_q.delete(); push_q.delete(); pop_q.delete();
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_ready"},    bus.instr_ready, 1);
        checkOutput({tag, "_ready_u"},  bus_u.instr_ready, 1);
        checkOutput({tag, "_trigger"},  bus.stack_trigger, 0);
        checkOutput({tag, "_push"},     bus.stack_push, 0);
        checkOutput({tag, "_op_done"},  bus.op_done, 0);
        checkOutput({tag, "_wdata"},    bus.stack_wdata, 0);
        checkOutput({tag, "_jmp"},      bus.jmp, 0);
        checkOutput({tag, "_jmp_addr"}, bus.jmp_addr, 0);
        checkOutput({tag, "_alu_op"},   bus.alu_op, 0);
        checkOutput({tag, "_alu_a"},    bus.alu_a, 0);
        checkOutput({tag, "_alu_b"},    bus.alu_b, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        dec_t d;
        logic seen;
        bus.instr_valid = 1'b0;
        bus.dec  = '0;
        bus.arg1 = '0;
        bus.arg2 = '0;
        stray_done = 1'b0;
        #2 rst = 1'b1;
        #1 checkReset("por");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] const push 5");
        d = blankDec(); d.constpush = 1; d.constval = 32'd5; d.stackwb = 1;
        push_q.push_back(32'd5);
        addExp(0, 1, 4, 0, 0, 0, '0, 0, '0, '0);
        applyStimulus(d, 8'h00, 8'h00);

        $display("[TB] nop");
        addExp(0, 0, 2, 0, 0, 0, '0, 0, '0, '0);
        applyStimulus(blankDec(), 8'h00, 8'h00);

        $display("[TB] arg push argc 2 / argc 1");
        d = blankDec(); d.isargpush = 1; d.argc = 2; d.stackwb = 1;
        push_q.push_back(32'hFFFF8001);
        addExp(0, 1, 4, 0, 0, 0, '0, 0, '0, '0);
        applyStimulus(d, 8'h80, 8'h01);
        d.argc = 1;
        push_q.push_back(32'hFFFFFFFE);
        addExp(0, 1, 4, 0, 0, 0, '0, 0, '0, '0);
        applyStimulus(d, 8'hFE, 8'h33);

        $display("[TB] iadd 7, 3");
        d = blankDec(); d.isaluop = 1; d.stackargs = 2; d.stackwb = 1;
        pop_q.push_back(32'd7); pop_q.push_back(32'd3);
        push_q.push_back(32'd10);
        addExp(2, 1, 8, 0, 0, 0, '0, 1, 32'd3, 32'd7);
        applyStimulus(d, 8'h00, 8'h00);

        $display("[TB] compare LT -1 < 1");
        d = blankDec(); d.iscmp = 1; d.cmptype = 4'b1010; d.stackargs = 2;
        pop_q.push_back(32'd1); pop_q.push_back(32'hFFFFFFFF);
        addExp(2, 0, 7, 1, 0, 1, 16'h0040, 1, 32'hFFFFFFFF, 32'd1);
        applyStimulus(d, 8'h00, 8'h40);

        $display("[TB] alu beats const push; jmp cleared");
        d = blankDec(); d.isaluop = 1; d.constpush = 1; d.constval = 32'h55; d.stackargs = 1; d.stackwb = 1;
        pop_q.push_back(32'd9);
        push_q.push_back(32'd9);
        addExp(1, 1, 6, 0, 0, 0, '0, 1, 32'd9, 32'd0);
        applyStimulus(d, 8'h00, 8'h00);

        $display("[TB] compare GE against zero");
        d = blankDec(); d.iscmp = 1; d.cmptype = 4'b0100; d.stackargs = 1;
        pop_q.push_back(32'h80000000);
        addExp(1, 0, 5, 0, 1, 1, 16'h1234, 0, '0, '0);
        applyStimulus(d, 8'h12, 8'h34);

        $display("[TB] undefined compare code");
        d = blankDec(); d.iscmp = 1; d.cmptype = 4'b1110; d.stackargs = 2;
        pop_q.push_back(32'd5); pop_q.push_back(32'd5);
        addExp(2, 0, 7, 0, 0, 1, 16'hABCD, 0, '0, '0);
        applyStimulus(d, 8'hAB, 8'hCD);

        $display("[TB] wide alu push");
        d = blankDec(); d.isaluop = 1; d.wide = 1; d.stackargs = 2; d.stackwb = 1;
        pop_q.push_back(32'd1); pop_q.push_back(32'd0);
        push_q.push_back(32'd1);
`ifdef WIDE_PUSH_EN
        push_q.push_back(32'd2);
        addExp(2, 2, 10, 0, 0, 0, '0, 1, 32'd0, 32'd1);
`else
        addExp(2, 1, 8, 0, 0, 0, '0, 1, 32'd0, 32'd1);
`endif
        applyStimulus(d, 8'h00, 8'h00);

        $display("[TB] stray stack_done while idle");
        @(posedge clk); #1 stray_done = 1'b1;
        @(posedge clk); #1 stray_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 checkOutput("idle_after_stray_done", bus.instr_ready, 1);

        $display("[TB] reset during POP_WAIT");
        d = blankDec(); d.isaluop = 1; d.stackargs = 2; d.stackwb = 1;
        pop_q.push_back(32'd7); pop_q.push_back(32'd3);
        @(posedge clk); #1;
        bus.dec = d; bus.arg1 = 8'h00; bus.arg2 = 8'h00; bus.instr_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.stack_trigger) begin seen = 1'b1; break; end
        end
        checkOutput("reset_test_pop_started", seen, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1 checkReset("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        pop_q.delete(); push_q.delete(); exp_q.delete();
        pop_q.push_back(32'd7); pop_q.push_back(32'd3);
        push_q.push_back(32'd10);
        addExp(2, 1, 8, 0, 0, 0, '0, 1, 32'd3, 32'd7);
        rst = 1'b0;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && push_q.size() == 0) break;
            @(posedge clk); #2;
        end
        checkOutput("post_reset_completion", exp_q.size() + push_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
